// File: rtl/pipe_perf_monitor.sv
// -----------------------------------------------------------------------------
// pipe_perf_monitor
//
// Purpose:
//   Event-counting monitor that runs alongside the 5-stage pipelined CPU.
//   While the CPU runs, it counts cycles, load-use stalls, IF/ID flushes and
//   retired instructions. The counters saturate at all-ones rather than wrap.
//   Counting stops permanently (DONE) once a programmable cycle budget is
//   reached. The selected counter is presented on a registered readout port.
//
// Optional feature (compile-time macro PERF_HANG_DETECT_EN):
//   Enables PC-history hang detection. A run of HANG_LIMIT consecutive
//   counting cycles with an unchanged PC and no stall moves the monitor into
//   HANG. HANG freezes the counters in the same way as DONE. Without the
//   macro, hang_o is tied to 0.
//
// Ports:
//   clk_i      in   1      clock, rising edge
//   rst_i      in   1      synchronous reset, active-high
//   start_i    in   1      CPU start; counting enabled while high
//   clear_i    in   1      synchronous clear of counters/flags, back to IDLE
//   stall_i    in   1      ID/EX load-use stall this cycle
//   flush_i    in   1      IF/ID flush this cycle
//   retire_i   in   1      instruction completing WB this cycle
//   pc_i       in   32     current PC
//   rd_sel_i   in   2      0 cycles, 1 stalls, 2 flushes, 3 retired
//   rd_data_o  out  CNT_W  selected counter, one cycle of latency
//   running_o  out  1      state == RUN
//   done_o     out  1      state == DONE
//   hang_o     out  1      state == HANG (0 without PERF_HANG_DETECT_EN)
//
// State  | meaning
// IDLE   | paused or not started, counters hold
// RUN    | counting every edge while start_i is high
// DONE   | cycle budget reached, counters frozen until clear/reset
// HANG   | PC stuck (optional feature only), counters frozen
// -----------------------------------------------------------------------------
module pipe_perf_monitor #(
    parameter int CNT_W       = 32,
    parameter int CYCLE_LIMIT = 30,
    parameter int HANG_LIMIT  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             retire_i,
    input  logic [31:0]      pc_i,
    input  logic [1:0]       rd_sel_i,
    output logic [CNT_W-1:0] rd_data_o,
    output logic             running_o,
    output logic             done_o,
    output logic             hang_o
);

`ifdef PERF_HANG_DETECT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_HANG} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] LIMIT_VAL = CNT_W'(CYCLE_LIMIT);
    localparam logic             LIMIT_EN  = (CYCLE_LIMIT != 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             count_en;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                  input logic en);
        return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
    endfunction

`ifdef PERF_HANG_DETECT_EN
    localparam int SAME_W = $clog2(HANG_LIMIT + 1);
    logic [31:0]       pc_prev_q, pc_prev_d;
    logic [SAME_W-1:0] same_cnt_q, same_cnt_d;
`else
    // pc_i and HANG_LIMIT only matter when hang detection is compiled in
    logic unused_hang_inputs;
    assign unused_hang_inputs = ^{pc_i, HANG_LIMIT[0]};
`endif

    always_comb begin
        state_d      = state_q;
        cycle_cnt_d  = cycle_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        retire_cnt_d = retire_cnt_q;
        count_en     = 1'b0;

        // readout shows counter values from before this edge
        case (rd_sel_i)
            2'd0:    rd_data_d = cycle_cnt_q;
            2'd1:    rd_data_d = stall_cnt_q;
            2'd2:    rd_data_d = flush_cnt_q;
            default: rd_data_d = retire_cnt_q;
        endcase

        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_RUN;
            ST_RUN:  if (start_i) count_en = 1'b1;
                     else         state_d  = ST_IDLE;
            default: state_d = state_q;
        endcase

        if (count_en) begin
            cycle_cnt_d  = sat_inc(cycle_cnt_q, 1'b1);
            stall_cnt_d  = sat_inc(stall_cnt_q, stall_i);
            flush_cnt_d  = sat_inc(flush_cnt_q, flush_i);
            retire_cnt_d = sat_inc(retire_cnt_q, retire_i);
            if (LIMIT_EN && (cycle_cnt_d == LIMIT_VAL)) state_d = ST_DONE;
        end

`ifdef PERF_HANG_DETECT_EN
        pc_prev_d  = pc_i;
        same_cnt_d = same_cnt_q;
        if (count_en) begin
            if (stall_i || (pc_i != pc_prev_q)) same_cnt_d = '0;
            else                                same_cnt_d = same_cnt_q + SAME_W'(1);
            // assigned after the DONE check so HANG wins a same-edge tie
            if (same_cnt_d == SAME_W'(HANG_LIMIT)) state_d = ST_HANG;
        end
`endif

        if (clear_i) begin
            state_d      = ST_IDLE;
            cycle_cnt_d  = '0;
            stall_cnt_d  = '0;
            flush_cnt_d  = '0;
            retire_cnt_d = '0;
`ifdef PERF_HANG_DETECT_EN
            same_cnt_d   = '0;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cycle_cnt_q  <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            retire_cnt_q <= '0;
            rd_data_q    <= '0;
`ifdef PERF_HANG_DETECT_EN
            pc_prev_q    <= '0;
            same_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cycle_cnt_q  <= cycle_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            retire_cnt_q <= retire_cnt_d;
            rd_data_q    <= rd_data_d;
`ifdef PERF_HANG_DETECT_EN
            pc_prev_q    <= pc_prev_d;
            same_cnt_q   <= same_cnt_d;
`endif
        end
    end

    assign rd_data_o = rd_data_q;
    assign running_o = (state_q == ST_RUN);
    assign done_o    = (state_q == ST_DONE);
`ifdef PERF_HANG_DETECT_EN
    assign hang_o    = (state_q == ST_HANG);
`else
    assign hang_o    = 1'b0;
`endif

endmodule
